// File: rtl/uart_fifo_pkg.sv
// Shared UART FIFO constants.
//   DEF_D_BIT  - default data word width
//   DEF_W      - default address width (depth = 2**DEF_W)
//   DEF_AE_LVL - default almost_empty threshold in words
//   def_af_lvl - default almost_full threshold for a given address width
package uart_fifo_pkg;

   localparam int unsigned DEF_D_BIT  = 8;
   localparam int unsigned DEF_W      = 4;
   localparam int unsigned DEF_AE_LVL = 2;

   // Two words short of full, so a producer has slack to stop.
   function automatic int unsigned def_af_lvl(input int unsigned w);
      return (2 ** w) - 2;
   endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO pointer, occupancy and status-flag control.
//   clk, rst       - clock, synchronous active-high reset
//   clr            - synchronous flush; wr/rd are ignored in that cycle
//   wr, rd         - push / pop requests
//   w_addr, r_addr - write / read pointers into storage
//   count          - words stored, 0..2**W
//   empty, full, almost_empty, almost_full - flags decoded from count
//   overflow       - sticky: push attempted while full (without a pop)
//   underflow      - sticky: pop attempted while empty
module fifo_ctrl
   import uart_fifo_pkg::*;
#(
   parameter int unsigned W      = DEF_W,
   parameter int unsigned AF_LVL = def_af_lvl(W),
   parameter int unsigned AE_LVL = DEF_AE_LVL
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         wr,
   input  logic         rd,
   output logic [W-1:0] w_addr,
   output logic [W-1:0] r_addr,
   output logic [W:0]   count,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic         overflow,
   output logic         underflow
);

   localparam int unsigned DEPTH = 2 ** W;

   logic [W-1:0] wptr_q, wptr_d;
   logic [W-1:0] rptr_q, rptr_d;
   logic [W:0]   count_q, count_d;
   logic         ovf_q, ovf_d;
   logic         udf_q, udf_d;
   logic         do_push, do_pop;

   // Flags come straight from the registered count.
   assign empty        = (count_q == '0);
   assign full         = (32'(count_q) == DEPTH);
   assign almost_empty = (32'(count_q) <= AE_LVL);
   assign almost_full  = (32'(count_q) >= AF_LVL);

   // A push while full is legal only when paired with a pop, which frees the slot.
   assign do_push = wr & (~full | rd);
   assign do_pop  = rd & ~empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end else begin
         if (do_push) wptr_d = wptr_q + W'(1);
         if (do_pop)  rptr_d = rptr_q + W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (W+1)'(1);
            2'b01:   count_d = count_q - (W+1)'(1);
            default: count_d = count_q;
         endcase
         if (wr && full && !rd) ovf_d = 1'b1;
         if (rd && empty)       udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign w_addr    = wptr_q;
   assign r_addr    = rptr_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule

// File: rtl/register_file.sv
// Register-file storage for the UART FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset.
//   clk    - clock
//   rst    - synchronous reset; only blocks writes, storage is not cleared
//   wr_en  - write strobe
//   w_addr - write address
//   r_addr - read address
//   w_data - write data
//   r_data - data at r_addr (combinational)
module register_file
   import uart_fifo_pkg::*;
#(
   parameter int unsigned D_BIT = DEF_D_BIT,
   parameter int unsigned W     = DEF_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [W-1:0]     w_addr,
   input  logic [W-1:0]     r_addr,
   input  logic [D_BIT-1:0] w_data,
   output logic [D_BIT-1:0] r_data
);

   logic [D_BIT-1:0] mem_q [2**W];

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[w_addr] <= w_data;
      end
   end

   assign r_data = mem_q[r_addr];

endmodule

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO for the UART data path.
//   clk, rst       - clock, synchronous active-high reset (highest priority)
//   clr            - synchronous flush
//   wr, w_data     - push request and data
//   rd             - pop request
//   r_data         - head word, valid only while empty=0
//   empty, full, almost_empty, almost_full - occupancy flags
//   count          - words stored, 0..2**W
//   overflow, underflow - sticky error flags, cleared by rst or clr
module uart_fifo
   import uart_fifo_pkg::*;
#(
   parameter int unsigned D_BIT  = DEF_D_BIT,
   parameter int unsigned W      = DEF_W,
   parameter int unsigned AF_LVL = def_af_lvl(W),
   parameter int unsigned AE_LVL = DEF_AE_LVL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr,
   input  logic [D_BIT-1:0] w_data,
   input  logic             rd,
   output logic [D_BIT-1:0] r_data,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [W:0]       count,
   output logic             overflow,
   output logic             underflow
);

   logic [W-1:0] w_addr;
   logic [W-1:0] r_addr;
   logic         wr_en;

   // Same acceptance rule as the controller's push, so storage and pointers agree.
   assign wr_en = wr & (~full | rd) & ~clr & ~rst;

   register_file #(
      .D_BIT (D_BIT),
      .W     (W)
   ) u_regs (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .w_addr (w_addr),
      .r_addr (r_addr),
      .w_data (w_data),
      .r_data (r_data)
   );

   fifo_ctrl #(
      .W      (W),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .wr           (wr),
      .rd           (rd),
      .w_addr       (w_addr),
      .r_addr       (r_addr),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .underflow    (underflow)
   );

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter D_BIT, default 8, data word width in bits.
REQ-002 SHALL have parameter W, default 4, address width; depth = 2**W words.
REQ-003 SHALL have parameter AF_LVL, default 2**W-2, almost_full threshold in words.
REQ-004 SHALL have parameter AE_LVL, default 2, almost_empty threshold in words.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port clr, input, 1 bit: synchronous flush request.
REQ-008 SHALL have port wr, input, 1 bit: push request.
REQ-009 SHALL have port w_data, input, D_BIT bits: push data.
REQ-010 SHALL have port rd, input, 1 bit: pop request.
REQ-011 SHALL have port r_data, output, D_BIT bits: head word (show-ahead).
REQ-012 SHALL have port empty, output, 1 bit: FIFO empty.
REQ-013 SHALL have port full, output, 1 bit: FIFO full.
REQ-014 SHALL have port almost_empty, output, 1 bit: count <= AE_LVL.
REQ-015 SHALL have port almost_full, output, 1 bit: count >= AF_LVL.
REQ-016 SHALL have port count, output, W+1 bits: words stored, range 0..2**W.
REQ-017 SHALL have port overflow, output, 1 bit: sticky, write attempted while full.
REQ-018 SHALL have port underflow, output, 1 bit: sticky, read attempted while empty.

Function
REQ-019 SHALL keep W-bit write and read pointers that wrap modulo 2**W, plus a registered W+1-bit count.
REQ-020 SHALL accept a push when wr=1 and full=0: store w_data at the write pointer, then increment the write pointer.
REQ-021 SHALL perform a pop when rd=1 and empty=0 by incrementing the read pointer.
REQ-022 SHALL drive r_data combinationally from storage at the read pointer; r_data is valid only when empty=0, and a pushed word appears on r_data in the cycle after its push edge.
REQ-023 SHALL derive empty, full, almost_empty and almost_full combinationally from the registered count, so each flag updates in the cycle after the causing edge.
REQ-024 SHALL, on wr=1 and rd=1 with 0<count<2**W, perform both operations and leave count unchanged.
REQ-025 SHALL, on wr=1 and rd=1 while full, perform both operations, leave count at 2**W and not set overflow.
REQ-026 SHALL, on wr=1 and rd=1 while empty, perform the push only, set count to 1 and set underflow.
REQ-027 SHALL ignore wr while full (storage and pointers unchanged) and set overflow.
REQ-028 SHALL ignore rd while empty and set underflow.
REQ-029 SHALL hold overflow and underflow at 1 until rst or clr.
REQ-030 SHALL, on clr=1, zero both pointers, count, overflow and underflow, and ignore wr and rd in that cycle; storage contents need not be cleared.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set both pointers, count, overflow and underflow to 0, giving empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-032 SHALL give rst priority over clr, wr and rd, and discard any in-flight data when rst is asserted mid-operation.
REQ-033 SHALL not reset storage contents; r_data is undefined while empty=1.

Structure
REQ-034 SHALL place the shared constants in the common UART parameter package: default D_BIT, default W, and the default threshold expressions.
REQ-035 SHALL instantiate the existing register_file (ports clk, rst, wr_en, w_addr, r_addr, w_data, r_data; parameters D_BIT and W) as storage.
REQ-036 SHALL drive register_file wr_en with wr & (~full | rd) & ~clr & ~rst.
REQ-037 SHALL implement pointer, count and flag logic in one sub-module, fifo_ctrl.

Verification
REQ-038 Bench SHALL check basic order: after reset, push 0xA1, 0xB2, 0xC3 then pop three times -> r_data shows A1, B2, C3 in that order; count goes 3, 2, 1, 0; empty=1 at the end.
REQ-039 Bench SHALL check fill and overflow (W=4): push 16 words 0x00..0x0F, then push 0xFF -> full=1, count=16, overflow=1; popping all 16 returns 0x00..0x0F and never 0xFF.
REQ-040 Bench SHALL check wrap-around: run 40 push/pop pairs with occupancy held at 5 -> pointers wrap twice, data order preserved, count stays 5.
REQ-041 Bench SHALL check simultaneous events: with full=1, assert wr and rd together with w_data=0x5A -> count stays 16, overflow stays 0, 0x5A is the last word popped; with empty=1, assert both -> count=1, underflow=1.
REQ-042 Bench SHALL check thresholds: with AF_LVL=14 and AE_LVL=2, push words one at a time -> almost_empty clears at count=3 and almost_full sets at count=14, each in the cycle after the push edge.
REQ-043 Bench SHALL check reset and clr mid-operation: with count=7 and overflow=1, assert clr -> count=0, empty=1, overflow=0; repeat with rst and wr=1 in the same cycle -> the write is discarded and count=0.
